// File: rtl/code_entry.sv
// code_entry: digit-entry front end for the password checker.
// Synchronises and debounces the ENTER/CLEAR push-buttons and samples the
// switch digit on each debounced ENTER press. Four decimal digits are
// assembled into a 16-bit BCD code, which is presented with a one-cycle strobe.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sw[3:0]      raw switch digit (asynchronous)
//   key_enter_n  raw ENTER button, active-low
//   key_clear_n  raw CLEAR button, active-low
//   code[15:0]   last completed code, first digit in [15:12]
//   code_valid   one-cycle strobe, aligned with the code update
//   digit_cnt    number of digits held in the partial buffer (0..3)
//   digit_err    one-cycle strobe: ENTER pressed while sw > 9
//
// state   | meaning
// --------+-------------------------------------------
// EMPTY   | no digits buffered (digit_cnt = 0)
// PARTIAL | 1..3 digits buffered, waiting for more

module code_entry #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  sw,
    input  logic        key_enter_n,
    input  logic        key_clear_n,
    output logic [15:0] code,
    output logic        code_valid,
    output logic [2:0]  digit_cnt,
    output logic        digit_err
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {EMPTY, PARTIAL} state_t;

    // Index 0 = ENTER, index 1 = CLEAR.
    logic [3:0]    sw_s1, sw_s2;
    logic [1:0]    key_s1, key_s2;
    logic [1:0]    key_db, key_db_d;
    logic [CW-1:0] db_cnt [2];
    logic [1:0]    press;

    state_t        state_q, state_nxt;
    logic [11:0]   dbuf_q, dbuf_nxt;
    logic [2:0]    cnt_q, cnt_nxt;
    logic [15:0]   code_q, code_nxt;
    logic          valid_q, valid_nxt;
    logic          err_q, err_nxt;

    // Synchronisers, debouncers and press-edge registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            key_s1   <= '1;
            key_s2   <= '1;
            key_db   <= '1;
            key_db_d <= '1;
            press    <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            key_s1 <= {key_clear_n, key_enter_n};
            key_s2 <= key_s1;
            for (int i = 0; i < 2; i++) begin
                if (key_s2[i] == key_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    // DEBOUNCE_CYCLES-th consecutive mismatch: accept the new level.
                    key_db[i] <= key_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
            key_db_d <= key_db;
            press    <= key_db_d & ~key_db;
        end
    end

    // FSM state register (with entry datapath).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            dbuf_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            dbuf_q  <= dbuf_nxt;
            cnt_q   <= cnt_nxt;
            code_q  <= code_nxt;
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
        end
    end

    // Next-state logic. CLEAR takes priority over a coincident ENTER.
    always_comb begin
        state_nxt = state_q;
        dbuf_nxt  = dbuf_q;
        cnt_nxt   = cnt_q;
        code_nxt  = code_q;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        if (press[1]) begin
            state_nxt = EMPTY;
            dbuf_nxt  = '0;
            cnt_nxt   = '0;
        end else if (press[0]) begin
            if (sw_s2 > 4'd9) begin
                err_nxt = 1'b1;
            end else if (cnt_q == 3'd3) begin
                code_nxt  = {dbuf_q, sw_s2};
                valid_nxt = 1'b1;
                dbuf_nxt  = '0;
                cnt_nxt   = '0;
                state_nxt = EMPTY;
            end else begin
                dbuf_nxt  = {dbuf_q[7:0], sw_s2};
                cnt_nxt   = cnt_q + 3'd1;
                state_nxt = PARTIAL;
            end
        end
    end

    // Outputs.
    always_comb begin
        code       = code_q;
        code_valid = valid_q;
        digit_cnt  = cnt_q;
        digit_err  = err_q;
    end

endmodule

// File: tb/tb_code_entry.sv
module tb_code_entry;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sw = 4'h0;
    logic        key_enter_n = 1'b1;
    logic        key_clear_n = 1'b1;
    logic [15:0] code;
    logic        code_valid;
    logic [2:0]  digit_cnt;
    logic        digit_err;

    int passed = 0;
    int total  = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_both  = 0;

    // Samples taken around the expected capture cycle of a press.
    logic [2:0]  pre_cnt, cap_cnt;
    logic        pre_valid, cap_valid, post_valid;
    logic        pre_err, cap_err, post_err;
    logic [15:0] cap_code;

    code_entry #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw),
        .key_enter_n(key_enter_n), .key_clear_n(key_clear_n),
        .code(code), .code_valid(code_valid),
        .digit_cnt(digit_cnt), .digit_err(digit_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid) n_valid++;
        if (digit_err) n_err++;
        if (code_valid && digit_err) n_both++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Press ENTER and/or CLEAR (raw level driven just after a falling edge)
    // and sample outputs 1 cycle before, at, and 1 cycle after N+4 clocks.
    task automatic press(input logic e, input logic c, input logic [3:0] d, input int hold);
        @(negedge clk);
        sw = d;
        repeat (3) @(negedge clk);
        key_enter_n = ~e;
        key_clear_n = ~c;
        repeat (N + 3) @(posedge clk);
        #1;
        pre_cnt = digit_cnt; pre_valid = code_valid; pre_err = digit_err;
        @(posedge clk); #1;
        cap_cnt = digit_cnt; cap_valid = code_valid; cap_err = digit_err; cap_code = code;
        @(posedge clk); #1;
        post_valid = code_valid; post_err = digit_err;
        if (hold > N + 5) repeat (hold - N - 5) @(posedge clk);
        @(negedge clk);
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (N + 8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    int v0, e0;

    initial begin
        do_reset();
        chk("rst_code", code, 16'h0);
        chk("rst_valid", {15'b0, code_valid}, 16'h0);
        chk("rst_cnt", {13'b0, digit_cnt}, 16'h0);
        chk("rst_err", {15'b0, digit_err}, 16'h0);

        // 1: clean 1,2,3,4 with exact latency
        press(1, 0, 4'd1, N + 6);
        chk("t1_pre_cnt1", {13'b0, pre_cnt}, 16'd0);
        chk("t1_cnt1", {13'b0, cap_cnt}, 16'd1);
        press(1, 0, 4'd2, N + 6);
        chk("t1_cnt2", {13'b0, cap_cnt}, 16'd2);
        press(1, 0, 4'd3, N + 6);
        chk("t1_cnt3", {13'b0, cap_cnt}, 16'd3);
        v0 = n_valid;
        press(1, 0, 4'd4, N + 6);
        chk("t1_pre_valid", {15'b0, pre_valid}, 16'd0);
        chk("t1_cap_valid", {15'b0, cap_valid}, 16'd1);
        chk("t1_post_valid", {15'b0, post_valid}, 16'd0);
        chk("t1_code", cap_code, 16'h1234);
        chk("t1_cnt0", {13'b0, cap_cnt}, 16'd0);
        chk("t1_nvalid", 16'(n_valid - v0), 16'd1);

        // 2: bouncy ENTER, sw = 7
        @(negedge clk); sw = 4'd7;
        repeat (3) @(negedge clk);
        v0 = n_valid; e0 = n_err;
        key_enter_n = 0; repeat (2) @(negedge clk);
        key_enter_n = 1; repeat (1) @(negedge clk);
        key_enter_n = 0; repeat (3) @(negedge clk);
        key_enter_n = 1; repeat (1) @(negedge clk);
        key_enter_n = 0; repeat (2) @(negedge clk);
        chk("t2_bounce_cnt", {13'b0, digit_cnt}, 16'd0);
        repeat (18) @(negedge clk);
        key_enter_n = 1;
        repeat (N + 8) @(negedge clk);
        chk("t2_cnt", {13'b0, digit_cnt}, 16'd1);
        chk("t2_strobes", 16'((n_valid - v0) + (n_err - e0)), 16'd0);

        // 3: invalid digit, then 9
        press(1, 0, 4'hA, N + 6);
        chk("t3_pre_err", {15'b0, pre_err}, 16'd0);
        chk("t3_cap_err", {15'b0, cap_err}, 16'd1);
        chk("t3_post_err", {15'b0, post_err}, 16'd0);
        chk("t3_cnt_hold", {13'b0, cap_cnt}, 16'd1);
        press(1, 0, 4'd9, N + 6);
        chk("t3_cnt_inc", {13'b0, cap_cnt}, 16'd2);

        // 4: CLEAR discards partial entry; then 5678
        press(0, 1, 4'd0, N + 6);
        chk("t4_clr_cnt", {13'b0, cap_cnt}, 16'd0);
        press(1, 0, 4'd1, N + 6);
        press(1, 0, 4'd2, N + 6);
        chk("t4_cnt2", {13'b0, digit_cnt}, 16'd2);
        v0 = n_valid;
        press(0, 1, 4'd0, N + 6);
        chk("t4_clr_cnt2", {13'b0, cap_cnt}, 16'd0);
        chk("t4_code_kept", code, 16'h1234);
        chk("t4_clr_novalid", 16'(n_valid - v0), 16'd0);
        press(1, 0, 4'd5, N + 6);
        press(1, 0, 4'd6, N + 6);
        press(1, 0, 4'd7, N + 6);
        v0 = n_valid;
        press(1, 0, 4'd8, N + 6);
        chk("t4_code", cap_code, 16'h5678);
        chk("t4_valid", {15'b0, cap_valid}, 16'd1);
        chk("t4_nvalid", 16'(n_valid - v0), 16'd1);

        // 5: reset mid-entry
        press(1, 0, 4'd1, N + 6);
        press(1, 0, 4'd1, N + 6);
        press(1, 0, 4'd1, N + 6);
        chk("t5_cnt3", {13'b0, digit_cnt}, 16'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_code", code, 16'h0);
        chk("t5_rst_cnt", {13'b0, digit_cnt}, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        press(1, 0, 4'd9, N + 6);
        press(1, 0, 4'd0, N + 6);
        press(1, 0, 4'd0, N + 6);
        press(1, 0, 4'd1, N + 6);
        chk("t5_code", cap_code, 16'h9001);
        chk("t5_valid", {15'b0, cap_valid}, 16'd1);

        // 6: long hold, then simultaneous ENTER+CLEAR
        v0 = n_valid; e0 = n_err;
        press(1, 0, 4'd3, 100);
        chk("t6_hold_cnt", {13'b0, digit_cnt}, 16'd1);
        press(1, 1, 4'd5, N + 6);
        chk("t6_sim_cnt", {13'b0, cap_cnt}, 16'd0);
        chk("t6_sim_strobes", 16'((n_valid - v0) + (n_err - e0)), 16'd0);
        chk("t6_code_kept", code, 16'h9001);
        chk("never_both", 16'(n_both), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
